// File: rtl/note_sequencer.sv
// Two-voice melody sequencer: walks a small note table, holds each entry for
// dur beats and announces frequency-id changes with a one-cycle new_f pulse.
module note_sequencer #(
    parameter int TICKS_PER_BEAT = 8125000,
    parameter int STEPS          = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        play,
    input  logic        loop,
    input  logic [1:0]  tempo,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [12:0] wr_data,
    output logic [4:0]  freq_id1,
    output logic [4:0]  freq_id2,
    output logic        new_f,
    output logic [4:0]  step,
    output logic        busy
);
    // state | meaning
    // IDLE  | silent, waiting for play
    // LOAD  | two-cycle table fetch (phase 0 address, phase 1 capture)
    // HOLD  | entry sounding, counting beats of the latched beat length

    localparam int          AW  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [23:0] TPB = 24'(TICKS_PER_BEAT);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic            ph_q, ph_d;
    logic [AW-1:0]   step_q, step_d;
    logic [4:0]      f1_q, f1_d, f2_q, f2_d;
    logic            new_f_q, new_f_d;
    logic            busy_q, busy_d;
    logic [23:0]     presc_q, presc_d;
    logic [23:0]     len_q, len_d;
    logic [2:0]      beats_q, beats_d;
    logic            seen_q, seen_d;
    logic            stop;
    logic [23:0]     beat_len;

    logic [12:0]     mem [STEPS];
    logic [12:0]     rd_q;

    // Read-before-write: a write to the address being fetched returns old data.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr[AW-1:0]] <= wr_data;
        rd_q <= mem[step_q];
    end

    assign beat_len = TPB >> tempo;

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        step_d  = step_q;
        f1_d    = f1_q;
        f2_d    = f2_q;
        new_f_d = 1'b0;
        presc_d = presc_q;
        len_d   = len_q;
        beats_d = beats_q;
        seen_d  = seen_q;
        stop    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (play) begin
                    state_d = S_LOAD;
                    ph_d    = 1'b0;
                    step_d  = '0;
                    seen_d  = 1'b0;
                end
            end
            S_LOAD: begin
                if (!play) begin
                    stop = 1'b1;
                end else if (!ph_q) begin
                    ph_d = 1'b1;
                end else if (rd_q[2:0] != 3'd0) begin
                    f1_d    = rd_q[12:8];
                    f2_d    = rd_q[7:3];
                    new_f_d = (f1_d != f1_q) || (f2_d != f2_q);
                    beats_d = rd_q[2:0];
                    presc_d = '0;
                    len_d   = beat_len;
                    seen_d  = 1'b1;
                    state_d = S_HOLD;
                end else if (loop && seen_q) begin
                    // seen_q stops an all-rest table from looping forever
                    step_d = '0;
                    ph_d   = 1'b0;
                    seen_d = 1'b0;
                end else begin
                    stop = 1'b1;
                end
            end
            S_HOLD: begin
                if (!play) begin
                    stop = 1'b1;
                end else if (24'(presc_q + 24'd1) >= len_q) begin
                    if (beats_q <= 3'd1) begin
                        state_d = S_LOAD;
                        ph_d    = 1'b0;
                        step_d  = step_q + 1'b1;
                    end else begin
                        beats_d = beats_q - 3'd1;
                        presc_d = '0;
                        len_d   = beat_len;
                    end
                end else begin
                    presc_d = presc_q + 24'd1;
                end
            end
            default: stop = 1'b1;
        endcase

        if (stop) begin
            state_d = S_IDLE;
            step_d  = '0;
            f1_d    = '0;
            f2_d    = '0;
            new_f_d = (f1_q != 5'd0) || (f2_q != 5'd0);
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ph_q    <= 1'b0;
            step_q  <= '0;
            f1_q    <= '0;
            f2_q    <= '0;
            new_f_q <= 1'b0;
            busy_q  <= 1'b0;
            presc_q <= '0;
            len_q   <= '0;
            beats_q <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            step_q  <= step_d;
            f1_q    <= f1_d;
            f2_q    <= f2_d;
            new_f_q <= new_f_d;
            busy_q  <= busy_d;
            presc_q <= presc_d;
            len_q   <= len_d;
            beats_q <= beats_d;
            seen_q  <= seen_d;
        end
    end

    assign freq_id1 = f1_q;
    assign freq_id2 = f2_q;
    assign new_f    = new_f_q;
    assign step     = 5'(step_q);
    assign busy     = busy_q;

endmodule
